// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the beat sequencer
// Contents: FSM state enum, setting opcodes, instruction field positions,
// and the tick accumulator denominator helper (CLK_HZ * 15).
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_EXEC,
    S_HOLD,
    S_HALTED
  } state_t;

  // Setting opcodes, instruction bits [3:1] when bit0 = 0
  localparam logic [2:0] OP_SET_BPM = 3'b000;
  localparam logic [2:0] OP_JUMP    = 3'b001;
  localparam logic [2:0] OP_HALT    = 3'b010;
  localparam logic [2:0] OP_SILENCE = 3'b011;

  // Instruction field positions
  localparam int F_KIND    = 0;
  localparam int F_CH_LO   = 1;
  localparam int F_CH_HI   = 2;
  localparam int F_NOTE_LO = 3;
  localparam int F_NOTE_HI = 8;
  localparam int F_WAIT_LO = 9;
  localparam int F_WAIT_HI = 12;
  localparam int F_OP_LO   = 1;
  localparam int F_OP_HI   = 3;
  localparam int F_BPM_LO  = 8;
  localparam int F_BPM_HI  = 15;
  localparam int F_JMP_LO  = 4;
  localparam int F_JMP_HI  = 15;

  // One sixteenth-beat is CLK_HZ*60/(bpm*4) cycles, i.e. TICK_DEN/bpm.
  function automatic logic [31:0] tick_den(input int clk_hz);
    return 32'(clk_hz) * 32'd15;
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// rtl/note_period_lut.sv - note number to tone half-period lookup
// Ports:
//   note   in  6      note number (1 = C2, 34 = A4; 0 unused by callers)
//   period out PER_W  half-period in clock cycles, round(CLK_HZ/(2*f(note)))
module note_period_lut #(
  parameter int CLK_HZ = 50_000_000,
  parameter int PER_W  = 20
) (
  input  logic [5:0]       note,
  output logic [PER_W-1:0] period
);

  // Evaluated only at elaboration; the table itself is plain constants.
  // Very high notes at low clock rates round to 0, so the result is clamped
  // to 1 (toggle every cycle); it is also clamped to the counter width.
  function automatic logic [PER_W-1:0] calc_period(input int n);
    real    freq;
    longint p;
    longint p_max;
    freq  = 880.0 * (2.0 ** ((real'(n) - 34.0) / 12.0));
    p     = longint'($rtoi(real'(CLK_HZ) / freq + 0.5));
    p_max = (longint'(1) <<< PER_W) - 1;
    if (p < 1) p = 1;
    if (p > p_max) p = p_max;
    return PER_W'(p);
  endfunction

  logic [PER_W-1:0] per_tab [64];

  for (genvar i = 0; i < 64; i++) begin : g_tab
    localparam logic [PER_W-1:0] P_I = calc_period(i);
    assign per_tab[i] = P_I;
  end

  assign period = per_tab[note];

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - tempo-driven SRAM instruction sequencer with tone channels
// Ports:
//   clk, rst   core clock, asynchronous active-high reset
//   start      pulse; leaves IDLE/HALTED and fetches at pc
//   sram_addr  registered SRAM word address; sram_data 16-bit read data
//   tone       per-channel square waves; speaker is their OR
//   pc, bpm    current fetch address and tempo; halted high in HALTED
module beat_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int ADDR_W      = 18,
  parameter int SRAM_LAT    = 2,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_BPM = 96,
  parameter int PER_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_data,
  output logic [NUM_CH-1:0] tone,
  output logic              speaker,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        bpm,
  output logic              halted
);

  localparam logic [31:0]  TICK_DEN = tick_den(CLK_HZ);
  localparam int           LAT_W    = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_LAT - 1);

  state_t state, state_nxt;

  logic [15:0]      instr;
  logic [LAT_W-1:0] lat_cnt;
  logic [3:0]       hold_left;
  logic [31:0]      acc;
  logic [31:0]      acc_sum;
  logic             tick;

  // Instruction decode
  logic       is_note;
  logic [2:0] op;
  logic [1:0] note_ch;
  logic [5:0] note_n;
  logic [3:0] note_d;
  logic [7:0] bpm_val;
  logic       is_set_bpm, is_jump, is_halt, is_silence;
  logic       exec_note, exec_silence;

  assign is_note    = instr[F_KIND];
  assign op         = instr[F_OP_HI:F_OP_LO];
  assign note_ch    = instr[F_CH_HI:F_CH_LO];
  assign note_n     = instr[F_NOTE_HI:F_NOTE_LO];
  assign note_d     = instr[F_WAIT_HI:F_WAIT_LO];
  assign bpm_val    = instr[F_BPM_HI:F_BPM_LO];
  assign is_set_bpm = !is_note && (op == OP_SET_BPM);
  assign is_jump    = !is_note && (op == OP_JUMP);
  assign is_halt    = !is_note && (op == OP_HALT);
  assign is_silence = !is_note && (op == OP_SILENCE);

  assign exec_note    = (state == S_EXEC) && is_note;
  assign exec_silence = (state == S_EXEC) && is_silence;

  // Exact rational tick: acc always stays below TICK_DEN, so the sum fits.
  assign acc_sum = acc + {24'd0, bpm};
  assign tick    = (acc_sum >= TICK_DEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = S_WAIT;
      S_WAIT:   if (lat_cnt == LAT_LAST) state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_halt)                     state_nxt = S_HALTED;
        else if (is_note && note_d != 0) state_nxt = S_HOLD;
        else                             state_nxt = S_ADDR;
      end
      S_HOLD:   if (tick && hold_left == 4'd1) state_nxt = S_ADDR;
      S_HALTED: if (start) state_nxt = S_ADDR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      sram_addr <= '0;
      bpm       <= 8'(DEFAULT_BPM);
      instr     <= '0;
      lat_cnt   <= '0;
      hold_left <= '0;
      acc       <= '0;
    end else begin
      if (state == S_EXEC && state_nxt == S_HOLD) acc <= '0;
      else if (tick)                              acc <= acc_sum - TICK_DEN;
      else                                        acc <= acc_sum;

      case (state)
        S_ADDR: begin
          sram_addr <= pc;
          lat_cnt   <= '0;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LAT_LAST) instr <= sram_data;
        end
        S_EXEC: begin
          if (is_jump)       pc <= ADDR_W'(instr[F_JMP_HI:F_JMP_LO]);
          else if (!is_halt) pc <= pc + 1'b1;
          if (is_set_bpm && bpm_val != 8'd0) bpm <= bpm_val;
          if (is_note) hold_left <= note_d;
        end
        S_HOLD: if (tick) hold_left <= hold_left - 4'd1;
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [5:0]       note_q;
    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] per;
    logic             tone_q;
    logic             load;

    note_period_lut #(.CLK_HZ(CLK_HZ), .PER_W(PER_W)) u_lut (
      .note   (note_q),
      .period (per)
    );

    // Channel fields beyond NUM_CH never match, so such notes are dropped.
    assign load = exec_note && (note_ch == 2'(c));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        note_q <= '0;
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (load) begin
        note_q <= note_n;
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (exec_silence || note_q == 6'd0) begin
        if (exec_silence) note_q <= '0;
        cnt_q  <= '0;
        tone_q <= 1'b0;
      end else if (cnt_q == per - PER_W'(1)) begin
        cnt_q  <= '0;
        tone_q <= ~tone_q;
      end else begin
        cnt_q <= cnt_q + PER_W'(1);
      end
    end

    assign tone[c] = tone_q;
  end

  assign speaker = |tone;
  assign halted  = (state == S_HALTED);

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - scoreboard bench for beat_sequencer
// An instruction-level interpreter schedules expected events (fetch address,
// post-execute pc/bpm/halted, channel loads) with their edge numbers; the
// monitor applies them and checks all outputs every cycle.
module tb_beat_sequencer;

  localparam int CLK_HZ   = 1600;
  localparam int ADDR_W   = 12;
  localparam int SRAM_LAT = 2;
  localparam int NUM_CH   = 2;
  localparam int DEF_BPM  = 96;
  localparam int PER_W    = 20;
  localparam int DEN      = CLK_HZ * 15;
  localparam int MEM_N    = 1 << ADDR_W;

  localparam logic [15:0] I_HALT    = 16'h0004;
  localparam logic [15:0] I_SILENCE = 16'h0006;
  localparam logic [15:0] I_NOP     = 16'h000E;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_data = '0;
  logic [NUM_CH-1:0] tone;
  logic              speaker;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        bpm;
  logic              halted;

  beat_sequencer #(
    .CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .SRAM_LAT(SRAM_LAT),
    .NUM_CH(NUM_CH), .DEFAULT_BPM(DEF_BPM), .PER_W(PER_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sram_addr(sram_addr),
    .sram_data(sram_data), .tone(tone), .speaker(speaker), .pc(pc),
    .bpm(bpm), .halted(halted)
  );

  always #5 clk = ~clk;

  // SRAM: one register stage, so data for a new address is ready SRAM_LAT edges later
  logic [15:0] mem [MEM_N];
  always @(posedge clk) sram_data <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
  endtask

  localparam int EV_START = 0, EV_ADDR = 1, EV_EXEC = 2;
  typedef struct {
    int t; int kind; int pc; int bpm; bit halt; int act; int ch; int n;
  } ev_t;
  ev_t q[$];

  // Monitor-side expected state
  bit chk_en = 1'b0;
  int exp_pc, exp_addr, exp_bpm, exp_halted;
  int ch_n [NUM_CH];
  int ch_l [NUM_CH];

  // Interpreter-side architectural state
  int m_pc, m_bpm;

  function automatic int p_of(input int n);
    real f;
    int  p;
    f = 880.0 * (2.0 ** ((real'(n) - 34.0) / 12.0));
    p = $rtoi(real'(CLK_HZ) / f + 0.5);
    if (p < 1) p = 1;
    return p;
  endfunction

  function automatic int exp_tone(input int c);
    if (ch_n[c] == 0) return 0;
    return ((cyc - ch_l[c]) / p_of(ch_n[c])) % 2;
  endfunction

  always @(negedge clk) begin
    ev_t ev;
    int  spk;
    if (chk_en) begin
      while (q.size() > 0 && q[0].t <= cyc) begin
        ev = q.pop_front();
        if (ev.t < cyc) chk("event_time", cyc, ev.t);
        case (ev.kind)
          EV_START: exp_halted = 0;
          EV_ADDR:  exp_addr = ev.pc;
          default: begin
            exp_pc = ev.pc; exp_bpm = ev.bpm; exp_halted = ev.halt;
            if (ev.act == 1) begin
              ch_n[ev.ch] = ev.n; ch_l[ev.ch] = cyc;
            end else if (ev.act == 2) begin
              for (int c = 0; c < NUM_CH; c++) ch_n[c] = 0;
            end
          end
        endcase
      end
      chk("pc", pc, exp_pc);
      chk("sram_addr", sram_addr, exp_addr);
      chk("bpm", bpm, exp_bpm);
      chk("halted", halted, exp_halted);
      spk = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("tone%0d", c), tone[c], exp_tone(c));
        spk = spk | exp_tone(c);
      end
      chk("speaker", speaker, spk);
    end
  end

  function automatic logic [15:0] f_note(input int ch, input int n, input int d);
    return {3'b000, 4'(d), 6'(n), 2'(ch), 1'b1};
  endfunction
  function automatic logic [15:0] f_bpm(input int b);
    return {8'(b), 8'h00};
  endfunction
  function automatic logic [15:0] f_jump(input int a);
    return {12'(a), 4'b0010};
  endfunction

  // Instruction-level interpreter. Called at a negedge; start is sampled at
  // the next edge N. Each instruction: fetch edge F, execute at F+1+SRAM_LAT,
  // then a hold of ceil(D*DEN/bpm) cycles before the next fetch edge.
  task automatic run_prog(input int max_exec, output int end_t, output bit did_halt);
    int t_f, e, d, n_exec, act, ch, n;
    logic [15:0] ins;
    t_f = cyc + 2;
    q.push_back('{t_f - 1, EV_START, 0, 0, 1'b0, 0, 0, 0});
    did_halt = 1'b0;
    n_exec = 0;
    e = t_f;
    while (n_exec < max_exec && !did_halt) begin
      q.push_back('{t_f, EV_ADDR, m_pc, 0, 1'b0, 0, 0, 0});
      ins = mem[m_pc];
      e = t_f + 1 + SRAM_LAT;
      d = 0; act = 0; ch = 0; n = 0;
      if (ins[0]) begin
        ch = int'(ins[2:1]);
        n  = int'(ins[8:3]);
        d  = int'(ins[12:9]);
        if (ch < NUM_CH) act = 1;
        m_pc = (m_pc + 1) % MEM_N;
      end else begin
        case (ins[3:1])
          3'd0: begin
            if (ins[15:8] != 0) m_bpm = int'(ins[15:8]);
            m_pc = (m_pc + 1) % MEM_N;
          end
          3'd1: m_pc = int'(ins[15:4]) % MEM_N;
          3'd2: did_halt = 1'b1;
          3'd3: begin act = 2; m_pc = (m_pc + 1) % MEM_N; end
          default: m_pc = (m_pc + 1) % MEM_N;
        endcase
      end
      q.push_back('{e, EV_EXEC, m_pc, m_bpm, did_halt, act, ch, n});
      n_exec++;
      if (d > 0) t_f = e + (d * DEN + m_bpm - 1) / m_bpm + 1;
      else       t_f = e + 1;
    end
    if (did_halt) end_t = e;
    else begin
      q.push_back('{t_f, EV_ADDR, m_pc, 0, 1'b0, 0, 0, 0});
      end_t = t_f;
    end
  endtask

  // Starts the program and runs until halt (or until the edge after the next
  // fetch when limited), pulsing start randomly while the sequencer is busy.
  task automatic go(input int max_exec);
    int end_t, guard;
    bit h;
    @(negedge clk);
    run_prog(max_exec, end_t, h);
    start = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (h ? (q.size() == 0) : (cyc >= end_t + 1)) break;
      if (guard > 60000) begin
        n_total++;
        $display("FAIL run_bound: waited %0d cycles, required end edge %0d", guard, end_t);
        break;
      end
      start = (cyc + 1 < end_t) && ($urandom_range(0, 40) == 0);
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    m_pc = 0; m_bpm = DEF_BPM;
    exp_pc = 0; exp_addr = 0; exp_bpm = DEF_BPM; exp_halted = 0;
    for (int c = 0; c < NUM_CH; c++) begin ch_n[c] = 0; ch_l[c] = 0; end
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'h0000;
  endtask

  function automatic logic [15:0] rand_instr(input int a, input int len);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3, 4:
        return f_note($urandom_range(0, 3), $urandom_range(0, 48), $urandom_range(0, 2))
               | {3'($urandom_range(0, 7)), 13'd0};
      5: return f_bpm(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(100, 255));
      6: return f_jump($urandom_range(a + 1, len));
      7: return I_SILENCE;
      8: return {12'($urandom()), 3'($urandom_range(4, 7)), 1'b0};
      default: return f_note($urandom_range(0, 1), $urandom_range(1, 48), 0);
    endcase
  endfunction

  initial begin
    int len;
    clear_mem();
    do_reset();
    idle(5);

    // Single note with one-tick hold, then halt; restart re-fetches the HALT word
    clear_mem();
    mem[0] = f_note(0, 34, 1);
    mem[1] = I_HALT;
    go(1000);
    idle(20);
    go(1000);
    idle(5);

    // bpm 0x60 rewrite, tempo doubled, two-tick hold
    do_reset();
    clear_mem();
    mem[0] = 16'h6000;
    mem[1] = f_bpm(192);
    mem[2] = f_note(0, 20, 2);
    mem[3] = I_HALT;
    go(1000);
    idle(5);

    // Forward jump skipping a note
    do_reset();
    clear_mem();
    mem[0] = I_NOP; mem[1] = I_NOP; mem[2] = I_NOP;
    mem[3] = f_jump(5);
    mem[4] = f_note(0, 10, 1);
    mem[5] = I_HALT;
    go(1000);
    idle(5);

    // Two running channels, an out-of-range channel, then silence on restart
    do_reset();
    clear_mem();
    mem[0] = f_note(0, 1, 0);
    mem[1] = f_note(1, 13, 0);
    mem[2] = f_note(3, 20, 0);
    mem[3] = I_HALT;
    go(1000);
    idle(100);
    mem[3] = I_SILENCE;
    mem[4] = I_HALT;
    go(1000);
    idle(20);

    // pc wrap at the top of the address space, then async reset during WAIT
    do_reset();
    clear_mem();
    mem[0] = f_bpm(200);
    mem[1] = f_note(0, 34, 0);
    mem[2] = f_jump(MEM_N - 1);
    mem[MEM_N - 1] = I_NOP;
    go(5);
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_bpm", bpm, DEF_BPM);
    chk("rst_halted", halted, 0);
    chk("rst_tone", tone, 0);
    chk("rst_speaker", speaker, 0);
    do_reset();
    idle(5);

    // Random forward-only programs ending in HALT
    for (int p = 0; p < 6; p++) begin
      do_reset();
      clear_mem();
      len = $urandom_range(5, 10);
      for (int a = 0; a < len; a++) mem[a] = rand_instr(a, len);
      mem[len] = I_HALT;
      go(1000);
      idle(10);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
